// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
//   Types and constants shared by the FPU sequential units.
//   - finv_seq_state_t : finv_seq control FSM states
//   - FINV_SEQ_LATENCY : accept-to-result latency of the divider path, in cycles
//   - FP_QNAN          : canonical quiet NaN
//   - FP_EXP_INF       : biased exponent field of inf/NaN
//   - finv_classify()  : operand class decode (zero/denormal, inf, NaN, power of 2)
// -----------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } finv_seq_state_t;

  localparam int          FINV_SEQ_LATENCY = 26;
  localparam logic [31:0] FP_QNAN          = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_INF       = 8'hFF;

  // Divider runs FINV_SEQ_LATENCY-1 cycles: counter loads this and counts to 0.
  localparam logic [4:0]  DIV_CNT_START    = 5'(FINV_SEQ_LATENCY - 2);

  typedef struct packed {
    logic zero_den; // e == 0
    logic inf;      // e == 255, man == 0
    logic nan;      // e == 255, man != 0
    logic pow2;     // normal with man == 0 (exact result)
  } finv_class_t;

  function automatic finv_class_t finv_classify(input logic [31:0] op);
    finv_class_t c;
    c.zero_den = (op[30:23] == 8'd0);
    c.inf      = (op[30:23] == FP_EXP_INF) && (op[22:0] == 23'd0);
    c.nan      = (op[30:23] == FP_EXP_INF) && (op[22:0] != 23'd0);
    c.pow2     = (op[30:23] != 8'd0) && (op[30:23] != FP_EXP_INF) &&
                 (op[22:0] == 23'd0);
    return c;
  endfunction

endpackage

// File: rtl/finv_rne_pack.sv
// -----------------------------------------------------------------------------
// finv_rne_pack
//   Combinational round-to-nearest-even and pack for a 24-bit quotient with
//   guard/sticky. Results with a final exponent field <= 0 are flushed to a
//   signed zero and flagged. Exponent overflow cannot occur for the reciprocal
//   and is not handled.
// Ports:
//   i_sign   : result sign
//   i_exp    : biased exponent before rounding (signed, 10 bits)
//   i_q      : quotient, i_q[23] is the hidden one
//   i_guard  : first bit below the quotient LSB
//   i_sticky : OR of all bits below guard
//   o_y      : packed single-precision result
//   o_udf    : result flushed to zero
// -----------------------------------------------------------------------------
module finv_rne_pack
  import fpu_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [9:0] i_exp,
  input  logic [23:0]       i_q,
  input  logic              i_guard,
  input  logic              i_sticky,
  output logic [31:0]       o_y,
  output logic              o_udf
);

  logic              w_inc;
  logic [24:0]       w_sum;
  logic signed [9:0] w_exp;
  logic [22:0]       w_frac;

  assign w_inc  = i_guard & (i_sticky | i_q[0]);
  assign w_sum  = {1'b0, i_q} + {24'd0, w_inc};
  // Carry-out means the mantissa became 2.0: renormalise, bump exponent.
  assign w_exp  = i_exp + $signed({9'd0, w_sum[24]});
  assign w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

  always_comb begin
    o_udf = (w_exp <= 10'sd0);
    o_y   = {i_sign, w_exp[7:0], w_frac};
    if (o_udf) begin
      o_y = {i_sign, 31'd0};
    end
  end

endmodule

// File: rtl/finv_seq.sv
// -----------------------------------------------------------------------------
// finv_seq
//   Sequential single-precision reciprocal y = 1/x, RNE, using a restoring
//   divider that retires one quotient bit per cycle. Denormal inputs are
//   treated as zero, denormal outputs are flushed to zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. in_ready is high only in IDLE and decodes the state register
//   only. out_valid is high only in DONE; y/ovf/udf hold steady until the
//   edge where out_ready is seen high, after which the unit returns to IDLE.
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : operand x valid          in_ready  : operand accepted in IDLE
//   x          : operand                  y         : result
//   out_valid  : y/ovf/udf valid          out_ready : consumer takes result
//   ovf        : input zero/denormal      udf       : result flushed to zero
//   dbg_state  : current FSM state (observation only)
//
// Build option: FINV_SEQ_FASTPATH_EN -- special and power-of-two operands
//   complete in IDLE -> DONE; otherwise every operand goes through DIV/ROUND.
// -----------------------------------------------------------------------------
module finv_seq
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     y,
  output logic            ovf,
  output logic            udf,
  output finv_seq_state_t dbg_state
);

  finv_seq_state_t r_state, w_next;

  logic [31:0] r_x;
  logic [4:0]  r_cnt;
  logic [24:0] r_rem;
  logic [24:0] r_q;
  logic [31:0] r_y;
  logic        r_ovf;
  logic        r_udf;

  logic        w_accept;
  logic        w_div_step;
  logic        w_load_result;

  // Operand being decoded: live input while accepting, captured copy after.
  logic [31:0] w_op;
  finv_class_t w_cls;
  logic        w_is_spec;
  logic [31:0] w_spec_y;
  logic        w_spec_ovf;
  logic        w_spec_udf;

  logic [23:0] w_d;
  logic        w_ge;
  logic [24:0] w_rem_sub;

  logic signed [9:0] w_pack_exp;
  logic [31:0]       w_pack_y;
  logic              w_pack_udf;

  // ---------------------------------------------------------------------------
  // Operand classification and special-case results
  // ---------------------------------------------------------------------------
  assign w_op      = (r_state == ST_IDLE) ? x : r_x;
  assign w_cls     = finv_classify(w_op);
  assign w_is_spec = w_cls.zero_den | w_cls.inf | w_cls.nan | w_cls.pow2;

  always_comb begin
    w_spec_y   = {w_op[31], 31'd0};
    w_spec_ovf = 1'b0;
    w_spec_udf = 1'b0;
    if (w_cls.zero_den) begin
      w_spec_y   = {w_op[31], FP_EXP_INF, 23'd0};
      w_spec_ovf = 1'b1;
    end else if (w_cls.nan) begin
      w_spec_y   = FP_QNAN;
    end else if (w_cls.pow2) begin
      // Exact result, exponent field 254-e; e == 254 lands on 0 and flushes.
      if (w_op[30:23] == 8'd254) begin
        w_spec_udf = 1'b1;
      end else begin
        w_spec_y = {w_op[31], 8'(8'd254 - w_op[30:23]), 23'd0};
      end
    end
    // inf input keeps the default signed zero with udf clear
  end

  // ---------------------------------------------------------------------------
  // Restoring divider: R starts at 2^24 so the first bit is always 1.
  // Special operands run on a harmless dummy divisor; their result is unused.
  // ---------------------------------------------------------------------------
  assign w_d       = w_is_spec ? 24'h800000 : {1'b1, r_x[22:0]};
  assign w_ge      = (r_rem >= {1'b0, w_d});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, w_d}) : r_rem;

  // 2/Mx is in (1,2), so the exponent field is 253-e before rounding.
  assign w_pack_exp = 10'sd253 - $signed({2'b00, r_x[30:23]});

  finv_rne_pack u_rne_pack (
    .i_sign   (r_x[31]),
    .i_exp    (w_pack_exp),
    .i_q      (r_q[24:1]),
    .i_guard  (r_q[0]),
    .i_sticky (r_rem != 25'd0),
    .o_y      (w_pack_y),
    .o_udf    (w_pack_udf)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    w_accept      = 1'b0;
    w_div_step    = 1'b0;
    w_load_result = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
`ifdef FINV_SEQ_FASTPATH_EN
          w_next   = w_is_spec ? ST_DONE : ST_DIV;
`else
          w_next   = ST_DIV;
`endif
        end
      end
      ST_DIV: begin
        w_div_step = 1'b1;
        if (r_cnt == 5'd0) begin
          w_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_load_result = 1'b1;
        w_next        = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x   <= 32'd0;
      r_cnt <= 5'd0;
      r_rem <= 25'd0;
      r_q   <= 25'd0;
      r_y   <= 32'd0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= x;
        r_cnt <= DIV_CNT_START;
        r_rem <= 25'h1000000;
        r_q   <= 25'd0;
`ifdef FINV_SEQ_FASTPATH_EN
        if (w_is_spec) begin
          r_y   <= w_spec_y;
          r_ovf <= w_spec_ovf;
          r_udf <= w_spec_udf;
        end
`endif
      end
      if (w_div_step) begin
        r_q   <= {r_q[23:0], w_ge};
        r_rem <= {w_rem_sub[23:0], 1'b0};
        if (r_cnt != 5'd0) begin
          r_cnt <= r_cnt - 5'd1;
        end
      end
      if (w_load_result) begin
        if (w_is_spec) begin
          r_y   <= w_spec_y;
          r_ovf <= w_spec_ovf;
          r_udf <= w_spec_udf;
        end else begin
          r_y   <= w_pack_y;
          r_ovf <= 1'b0;
          r_udf <= w_pack_udf;
        end
      end
    end
  end

  assign y         = r_y;
  assign ovf       = r_ovf;
  assign udf       = r_udf;
  assign dbg_state = r_state;

endmodule
